// File: rtl/i2c_tx_fifo.sv
// i2c_tx_fifo: transmit FIFO between the APB bridge (push side) and the
// I2C core (pop side). The pointers carry one wrap bit above the index, so
// full and empty can be told apart without a separate counter. The read
// path is registered, so a popped word appears one cycle after RD_ENA.
// DATA_VALID pulses with each new word, and the overflow and underflow
// flags stay set until CLR_ERR clears them.
module i2c_tx_fifo #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              WR_ENA,
    input  logic [DWIDTH-1:0] WRITE_DATA_ON_TX,
    input  logic              RD_ENA,
    input  logic              CLR_ERR,
    output logic [DWIDTH-1:0] DATA_OUT,
    output logic              DATA_VALID,
    output logic              TX_EMPTY,
    output logic              TX_FULL,
    output logic [AWIDTH:0]   FILL_LEVEL,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

    // Full means the index bits are equal and the wrap bits differ.
    function automatic logic ptr_full(input logic [AWIDTH:0] w, input logic [AWIDTH:0] r);
        return (w[AWIDTH-1:0] == r[AWIDTH-1:0]) && (w[AWIDTH] != r[AWIDTH]);
    endfunction

    // Empty means the two pointers match, wrap bit included.
    function automatic logic ptr_empty(input logic [AWIDTH:0] w, input logic [AWIDTH:0] r);
        return (w == r);
    endfunction

    logic [DWIDTH-1:0] mem_r [DEPTH];
    logic [AWIDTH:0]   wptr_r;
    logic [AWIDTH:0]   rptr_r;
    logic [AWIDTH:0]   fill_r;
    logic              empty_r;
    logic              full_r;
    logic [DWIDTH-1:0] dout_r;
    logic              valid_r;
    logic              ovf_r;
    logic              unf_r;

    logic              empty_s;
    logic              full_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              ovf_set_s;
    logic              unf_set_s;
    logic [AWIDTH:0]   wptr_nxt_s;
    logic [AWIDTH:0]   rptr_nxt_s;

    // Accept/reject decisions and next-pointer values for this cycle.
    always_comb begin
        empty_s    = ptr_empty(wptr_r, rptr_r);
        full_s     = ptr_full(wptr_r, rptr_r);
        rd_acc_s   = RD_ENA && !empty_s;
        // A push while full still fits when a pop frees a slot on the same edge.
        wr_acc_s   = WR_ENA && (!full_s || rd_acc_s);
        ovf_set_s  = WR_ENA && !wr_acc_s;
        unf_set_s  = RD_ENA && empty_s;
        if (wr_acc_s) begin
            wptr_nxt_s = wptr_r + PTR_ONE;
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (rd_acc_s) begin
            rptr_nxt_s = rptr_r + PTR_ONE;
        end else begin
            rptr_nxt_s = rptr_r;
        end
    end

    // Storage array. It has no reset because the pointer reset makes any stale entries unreachable.
    always_ff @(posedge PCLK) begin
        if (wr_acc_s) begin
            mem_r[wptr_r[AWIDTH-1:0]] <= WRITE_DATA_ON_TX;
        end
    end

    // Pointers and status outputs, registered from the post-edge pointer values.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wptr_r  <= {(AWIDTH+1){1'b0}};
            rptr_r  <= {(AWIDTH+1){1'b0}};
            fill_r  <= {(AWIDTH+1){1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            wptr_r  <= wptr_nxt_s;
            rptr_r  <= rptr_nxt_s;
            fill_r  <= wptr_nxt_s - rptr_nxt_s;
            empty_r <= ptr_empty(wptr_nxt_s, rptr_nxt_s);
            full_r  <= ptr_full(wptr_nxt_s, rptr_nxt_s);
        end
    end

    // Registered read port. DATA_OUT holds its value until the next accepted pop.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            dout_r  <= {DWIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                dout_r <= mem_r[rptr_r[AWIDTH-1:0]];
            end
        end
    end

    // Sticky error flags. A new event in the same cycle wins over CLR_ERR.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (CLR_ERR) begin
                ovf_r <= 1'b0;
            end
            if (unf_set_s) begin
                unf_r <= 1'b1;
            end else if (CLR_ERR) begin
                unf_r <= 1'b0;
            end
        end
    end

    assign DATA_OUT   = dout_r;
    assign DATA_VALID = valid_r;
    assign TX_EMPTY   = empty_r;
    assign TX_FULL    = full_r;
    assign FILL_LEVEL = fill_r;
    assign OVERFLOW   = ovf_r;
    assign UNDERFLOW  = unf_r;

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Testbench for i2c_tx_fifo. The reference model is a data queue with
// sticky-flag bookkeeping. Directed scenarios run first, followed by a long
// random push/pop run.
module tb_i2c_tx_fifo;

    localparam int DEPTH = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        WR_ENA;
    logic [31:0] WRITE_DATA_ON_TX;
    logic        RD_ENA;
    logic        CLR_ERR;
    logic [31:0] DATA_OUT;
    logic        DATA_VALID;
    logic        TX_EMPTY;
    logic        TX_FULL;
    logic [4:0]  FILL_LEVEL;
    logic        OVERFLOW;
    logic        UNDERFLOW;

    int          errors = 0;
    int          checks = 0;

    logic [31:0] q[$];
    logic [31:0] m_dout;
    logic        m_valid;
    logic        m_ovf;
    logic        m_unf;

    // Free-running 10 ns clock.
    always #5 PCLK = ~PCLK;

    i2c_tx_fifo #(.DWIDTH(32), .AWIDTH(4)) dut (
        .PCLK             (PCLK),
        .PRESET           (PRESET),
        .WR_ENA           (WR_ENA),
        .WRITE_DATA_ON_TX (WRITE_DATA_ON_TX),
        .RD_ENA           (RD_ENA),
        .CLR_ERR          (CLR_ERR),
        .DATA_OUT         (DATA_OUT),
        .DATA_VALID       (DATA_VALID),
        .TX_EMPTY         (TX_EMPTY),
        .TX_FULL          (TX_FULL),
        .FILL_LEVEL       (FILL_LEVEL),
        .OVERFLOW         (OVERFLOW),
        .UNDERFLOW        (UNDERFLOW)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_out",   DATA_OUT, m_dout);
        chk("data_valid", 32'(DATA_VALID), 32'(m_valid));
        chk("tx_empty",   32'(TX_EMPTY), 32'(q.size() == 0));
        chk("tx_full",    32'(TX_FULL), 32'(q.size() == DEPTH));
        chk("fill_level", 32'(FILL_LEVEL), 32'(q.size()));
        chk("overflow",   32'(OVERFLOW), 32'(m_ovf));
        chk("underflow",  32'(UNDERFLOW), 32'(m_unf));
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = 32'h0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Drive one cycle of inputs, update the model, then compare after the edge.
    task automatic step(input logic wr, input logic rd, input logic clr, input logic [31:0] d);
        int   n;
        logic rd_ok;
        WR_ENA           = wr;
        RD_ENA           = rd;
        CLR_ERR          = clr;
        WRITE_DATA_ON_TX = d;
        n     = q.size();
        rd_ok = rd && (n > 0);
        m_valid = rd_ok;
        if (rd_ok) m_dout = q.pop_front();
        if (wr && ((n < DEPTH) || rd_ok)) q.push_back(d);
        if (wr && (n == DEPTH) && !rd) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (rd && (n == 0)) m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
        @(posedge PCLK);
        #1;
        check_all();
    endtask

    initial begin
        int pw;
        PRESET = 1'b1;
        WR_ENA = 1'b0;
        RD_ENA = 1'b0;
        CLR_ERR = 1'b0;
        WRITE_DATA_ON_TX = 32'h0;
        model_reset();
        #1;
        check_all();
        #11;
        PRESET = 1'b0;
        @(posedge PCLK);
        #1;

        // Basic ordering, one-cycle read latency and DATA_VALID pulses
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0, 32'hA5A5_0000 + 32'(i));
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("pop_seq", DATA_OUT, 32'hA5A5_0000 + 32'(i));
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("empty_after_pops", 32'(TX_EMPTY), 32'd1);

        // Fill completely, then overflow. The dropped word must never appear.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, $urandom & 32'h7FFF_FFFF);
        chk("full_flag", 32'(TX_FULL), 32'd1);
        chk("full_level", 32'(FILL_LEVEL), 32'd16);
        step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("overflow_set", 32'(OVERFLOW), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("no_deadbeef", 32'(DATA_OUT === 32'hDEAD_BEEF), 32'd0);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);

        // Simultaneous push/pop while full, across pointer wrap
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h2000 + 32'(i));
            chk("full_rw_level", 32'(FILL_LEVEL), 32'd16);
            chk("full_rw_ovf", 32'(OVERFLOW), 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

        // Underflow, clearing it, and push+pop on an empty FIFO
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("underflow_set", 32'(UNDERFLOW), 32'd1);
        chk("underflow_novalid", 32'(DATA_VALID), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("underflow_clr", 32'(UNDERFLOW), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h5555_AAAA);
        chk("empty_rw_level", 32'(FILL_LEVEL), 32'd1);
        chk("empty_rw_unf", 32'(UNDERFLOW), 32'd1);
        step(1'b0, 1'b1, 1'b1, 32'h0);
        chk("empty_rw_word", DATA_OUT, 32'h5555_AAAA);

        // Mid-cycle reset while a push is in progress
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h3000 + 32'(i));
        WR_ENA = 1'b1;
        WRITE_DATA_ON_TX = 32'h3333_3333;
        #3;
        PRESET = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge PCLK);
        #1;
        WR_ENA = 1'b0;
        PRESET = 1'b0;
        check_all();
        step(1'b1, 1'b0, 1'b0, 32'hC0FF_EE01);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("post_reset_word", DATA_OUT, 32'hC0FF_EE01);

        // Random push/pop run, with the push/pop bias changing every 256 cycles
        pw = 50;
        for (int i = 0; i < 10000; i++) begin
            if ((i % 256) == 0) begin
                case ($urandom_range(2, 0))
                    0: pw = 20;
                    1: pw = 50;
                    default: pw = 80;
                endcase
            end
            step(int'($urandom_range(99, 0)) < pw,
                 int'($urandom_range(99, 0)) < (100 - pw),
                 $urandom_range(31, 0) == 0,
                 $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
